stream_frame_status_tracker: RTL and testbench

STREAM_FRAME_STATUS_TRACKER -- requirements
Module: stream_frame_status_tracker

---
 rtl/stream_frame_status_tracker_pkg.sv | 32 +++
 rtl/stream_status_fifo.sv | 52 +++++
 rtl/stream_frame_status_tracker.sv | 138 +++++++++++++
 tb/tb_stream_frame_status_tracker.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_frame_status_tracker_pkg.sv
// Shared constants and status-word layout helpers
// for the stream frame status tracker.
package stream_frame_status_tracker_pkg;

  localparam int DEF_DATA_WIDTH   = 512;
  localparam int DEF_ERR_BITS     = 2;
  localparam int DEF_SEQ_BITS     = 1;
  localparam int DEF_LEN_BITS     = 16;
  localparam int DEF_STATUS_DEPTH = 4;

  localparam int ERR_OFF = 0;

  function automatic int status_w(
    input int err_bits,
    input int len_bits
  );
    return ((err_bits + 2 + len_bits + 7) / 8) * 8;
  endfunction

  function automatic int seq_err_off(input int err_bits);
    return err_bits;
  endfunction

  function automatic int len_ovf_off(input int err_bits);
    return err_bits + 1;
  endfunction

  function automatic int count_off(input int err_bits);
    return err_bits + 2;
  endfunction

endpackage

// File: rtl/stream_status_fifo.sv
// Status FIFO: WIDTH x DEPTH (power of 2), full/empty flags.
// Ports: aclk, aresetn, push/din, pop/dout, full, empty.
module stream_status_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_q];

  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_q] <= din;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/stream_frame_status_tracker.sv
// Accumulates per-frame error/sequence/length status, queues it.
// Ports: aclk/aresetn, s_axis_* in, m_axis_* status out, counters.
module stream_frame_status_tracker
  import stream_frame_status_tracker_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ERR_BITS     = DEF_ERR_BITS,
  parameter int SEQ_BITS     = DEF_SEQ_BITS,
  parameter int LEN_BITS     = DEF_LEN_BITS,
  parameter int STATUS_DEPTH = DEF_STATUS_DEPTH
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [ERR_BITS+SEQ_BITS-1:0] s_axis_tuser,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic [status_w(ERR_BITS, LEN_BITS)-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [31:0]               frames_total,
  output logic [31:0]               frames_bad
);

  localparam int SW   = status_w(ERR_BITS, LEN_BITS);
  localparam int UW   = ERR_BITS + SEQ_BITS;
  localparam int SE_B = seq_err_off(ERR_BITS);
  localparam int OV_B = len_ovf_off(ERR_BITS);
  localparam int CN_B = count_off(ERR_BITS);

  logic                run_q;
  logic [SEQ_BITS-1:0] exp_q;
  logic [ERR_BITS-1:0] err_q;
  logic                seq_err_q;
  logic                ovf_q;
  logic [LEN_BITS-1:0] cnt_q;

  logic [SEQ_BITS-1:0] seq;
  logic [ERR_BITS-1:0] err;
  logic                beat;
  logic                push;
  logic                first;
  logic                full;
  logic                empty;

  logic [ERR_BITS-1:0] err_n;
  logic                seq_bad;
  logic                seq_err_n;
  logic                ovf_n;
  logic [LEN_BITS-1:0] cnt_n;
  logic [SW-1:0]       status;
  logic                bad;

  wire unused_data = ^s_axis_tdata;

  assign seq   = s_axis_tuser[SEQ_BITS-1:0];
  assign err   = s_axis_tuser[UW-1:SEQ_BITS];
  assign beat  = s_axis_tvalid && s_axis_tready;
  assign push  = beat && s_axis_tlast;
  // Count saturates above zero, so zero marks "no beat yet".
  assign first = (cnt_q == '0);

  assign s_axis_tready = run_q && !full;
  assign m_axis_tvalid = !empty;

  always_comb begin
    err_n     = err | (first ? '0 : err_q);
    seq_bad   = 1'b0;
    if (first) seq_bad = (SEQ_BITS == 1) && (seq != '0);
    else       seq_bad = (seq != exp_q);
    seq_err_n = seq_bad | (!first && seq_err_q);
    cnt_n     = cnt_q;
    ovf_n     = ovf_q;
    if (first) begin
      cnt_n = LEN_BITS'(1);
      ovf_n = 1'b0;
    end else if (cnt_q == '1) begin
      ovf_n = 1'b1;
    end else begin
      cnt_n = cnt_q + LEN_BITS'(1);
    end
    status                  = '0;
    status[ERR_BITS-1:0]    = err_n;
    status[SE_B]            = seq_err_n;
    status[OV_B]            = ovf_n;
    status[CN_B +: LEN_BITS] = cnt_n;
    bad = (|err_n) | seq_err_n | ovf_n;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run_q        <= 1'b0;
      exp_q        <= '0;
      err_q        <= '0;
      seq_err_q    <= 1'b0;
      ovf_q        <= 1'b0;
      cnt_q        <= '0;
      frames_total <= '0;
      frames_bad   <= '0;
    end else begin
      run_q <= 1'b1;
      if (beat) begin
        exp_q <= seq + SEQ_BITS'(1);
        if (s_axis_tlast) begin
          err_q     <= '0;
          seq_err_q <= 1'b0;
          ovf_q     <= 1'b0;
          cnt_q     <= '0;
        end else begin
          err_q     <= err_n;
          seq_err_q <= seq_err_n;
          ovf_q     <= ovf_n;
          cnt_q     <= cnt_n;
        end
      end
      if (push) begin
        frames_total <= frames_total + 32'd1;
        if (bad) frames_bad <= frames_bad + 32'd1;
      end
    end
  end

  stream_status_fifo #(
    .WIDTH (SW),
    .DEPTH (STATUS_DEPTH)
  ) u_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (push),
    .din     (status),
    .pop     (m_axis_tvalid && m_axis_tready),
    .dout    (m_axis_tdata),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: tb/tb_stream_frame_status_tracker.sv
// Scoreboard bench: two tracker configurations share one
// random stream; a frame-level model predicts each status.
module tb_stream_frame_status_tracker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_data = '0;
  logic [2:0]  user_a = '0;
  logic [5:0]  user_b = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        m_ready = 1'b0;
  int          mode = 1;

  wire         rdy_a, rdy_b, mv_a, mv_b;
  wire [23:0]  md_a;
  wire [7:0]   md_b;
  wire [31:0]  ft_a, fb_a, ft_b, fb_b;

  always #5 clk = ~clk;

  stream_frame_status_tracker #(
    .DATA_WIDTH(32), .ERR_BITS(2), .SEQ_BITS(1),
    .LEN_BITS(16), .STATUS_DEPTH(4)
  ) dut_a (
    .aclk(clk), .aresetn(rst_n),
    .s_axis_tdata(s_data), .s_axis_tuser(user_a),
    .s_axis_tvalid(s_valid), .s_axis_tlast(s_last),
    .s_axis_tready(rdy_a),
    .m_axis_tdata(md_a), .m_axis_tvalid(mv_a),
    .m_axis_tready(m_ready),
    .frames_total(ft_a), .frames_bad(fb_a)
  );

  stream_frame_status_tracker #(
    .DATA_WIDTH(32), .ERR_BITS(2), .SEQ_BITS(4),
    .LEN_BITS(3), .STATUS_DEPTH(4)
  ) dut_b (
    .aclk(clk), .aresetn(rst_n),
    .s_axis_tdata(s_data), .s_axis_tuser(user_b),
    .s_axis_tvalid(s_valid), .s_axis_tlast(s_last),
    .s_axis_tready(rdy_b),
    .m_axis_tdata(md_b), .m_axis_tvalid(mv_b),
    .m_axis_tready(m_ready),
    .frames_total(ft_b), .frames_bad(fb_b)
  );

  int n_chk = 0;
  int n_pass = 0;

  int          fseq[$];
  int          ferr[$];
  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  int tot_a = 0, bad_a = 0, tot_b = 0, bad_b = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  function automatic logic [31:0] model(
    input int sb, input int lb, output bit bad);
    int m, mx, e, n, cnt;
    bit se, ovf;
    m = 1 << sb;
    mx = (1 << lb) - 1;
    n = fseq.size();
    e = 0;
    se = 0;
    for (int i = 0; i < n; i++) begin
      e |= ferr[i];
      if (i == 0) begin
        if (sb == 1 && (fseq[0] % m) != 0) se = 1;
      end else if ((fseq[i] % m) != ((fseq[i-1] + 1) % m)) begin
        se = 1;
      end
    end
    ovf = n > mx;
    cnt = ovf ? mx : n;
    bad = (e != 0) || se || ovf;
    return 32'(e) | (32'(se) << 2) | (32'(ovf) << 3)
         | (32'(cnt) << 4);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(int seq, int err, bit last);
    int w;
    bit b;
    w = 0;
    s_valid = 1'b1;
    s_last = last;
    s_data = $urandom;
    user_a = {err[1:0], seq[0]};
    user_b = {err[1:0], seq[3:0]};
    while (!rdy_a && w < 2000) begin
      tick;
      w++;
    end
    if (!rdy_a) begin
      n_chk++;
      $display("FAIL beat_timeout: tready stayed 0");
      s_valid = 1'b0;
      return;
    end
    tick;
    fseq.push_back(seq);
    ferr.push_back(err);
    if (last) begin
      exp_a.push_back(model(1, 16, b));
      tot_a++;
      bad_a += int'(b);
      exp_b.push_back(model(4, 3, b));
      tot_b++;
      bad_b += int'(b);
      fseq.delete();
      ferr.delete();
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic send_frame(int n, int seq0, bit cont);
    int s, e;
    for (int i = 0; i < n; i++) begin
      s = cont ? ((seq0 + i) & 15) : int'($urandom % 16);
      e = ($urandom % 6 == 0) ? int'($urandom % 4) : 0;
      if ($urandom % 4 == 0) tick;
      send_beat(s, e, i == n - 1);
    end
  endtask

  task automatic chk_counts;
    chk("frames_total_a", ft_a, tot_a);
    chk("frames_bad_a", fb_a, bad_a);
    chk("frames_total_b", ft_b, tot_b);
    chk("frames_bad_b", fb_b, bad_b);
  endtask

  task automatic drain;
    int w;
    w = 0;
    mode = 1;
    while ((exp_a.size() != 0 || exp_b.size() != 0)
           && w < 2000) begin
      tick;
      w++;
    end
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: %0d/%0d left",
               exp_a.size(), exp_b.size());
    end
    tick;
    chk_counts();
  endtask

  initial begin
    forever begin
      tick;
      case (mode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = 1'($urandom % 2);
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (mv_a && m_ready) begin
        if (exp_a.size() == 0) begin
          n_chk++;
          $display("FAIL status_a: got %0h expected none", md_a);
        end else begin
          chk("status_a", 32'(md_a), exp_a.pop_front());
        end
      end
      if (mv_b && m_ready) begin
        if (exp_b.size() == 0) begin
          n_chk++;
          $display("FAIL status_b: got %0h expected none", md_b);
        end else begin
          chk("status_b", 32'(md_b), exp_b.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (3) tick;
    chk("rst_tvalid", 32'(mv_a), 0);
    chk("rst_tready", 32'(rdy_a), 0);
    chk("rst_tdata", 32'(md_a), 0);
    chk("rst_total", ft_a, 0);
    rst_n = 1'b1;
    chk("tready_pre_edge", 32'(rdy_b), 0);
    tick;
    chk("tready_post_edge", 32'(rdy_a), 1);
    chk("tready_post_edge_b", 32'(rdy_b), 1);

    send_beat(0, 0, 0); send_beat(1, 0, 0);
    send_beat(0, 0, 0); send_beat(1, 0, 1);
    drain();

    send_beat(3, 0, 0); send_beat(4, 0, 0);
    send_beat(6, 0, 0); send_beat(7, 0, 1);
    drain();

    send_beat(0, 0, 0); send_beat(1, 2, 0);
    send_beat(2, 0, 1);
    send_beat(0, 0, 0); send_beat(1, 0, 0);
    send_beat(2, 0, 1);
    drain();

    for (int i = 0; i < 9; i++) send_beat(i, 0, i == 8);
    drain();

    mode = 0;
    tick;
    for (int i = 0; i < 4; i++) send_beat(0, i, 1);
    tick;
    chk("full_tready_a", 32'(rdy_a), 0);
    chk("full_tready_b", 32'(rdy_b), 0);
    chk("full_tvalid", 32'(mv_a), 1);
    fork
      send_beat(0, 1, 1);
      begin
        repeat (5) tick;
        mode = 1;
      end
    join
    drain();

    mode = 2;
    repeat (40)
      send_frame(int'($urandom_range(1, 10)),
                 int'($urandom % 16), ($urandom % 3) != 0);
    drain();

    mode = 0;
    send_beat(0, 3, 1);
    send_beat(0, 0, 0);
    s_valid = 1'b1;
    user_a = 3'b010;
    user_b = 6'b000001;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tvalid_a", 32'(mv_a), 0);
    chk("arst_tvalid_b", 32'(mv_b), 0);
    chk("arst_tready", 32'(rdy_a), 0);
    chk("arst_tdata", 32'(md_a), 0);
    s_valid = 1'b0;
    fseq.delete(); ferr.delete();
    exp_a.delete(); exp_b.delete();
    tot_a = 0; bad_a = 0; tot_b = 0; bad_b = 0;
    repeat (2) tick;
    rst_n = 1'b1;
    tick;
    chk_counts();
    mode = 1;
    send_beat(0, 0, 0); send_beat(1, 0, 0);
    send_beat(2, 0, 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
